axis_complex_weighter: RTL and testbench

// - Per-channel beamforming weight stage; sits directly upstream of the 4-channel axis_adder (one instance per channel).
// - Multiplies each complex sample of a paired real/imag AXI stream by one complex weight.
// - Rounds and saturates each product back to 16 bits, then emits paired real/imag streams with tlast preserved.
// - Weights are double-buffered and change only on frame boundaries.

---
 rtl/axis_complex_weighter_if.sv | 33 +++
 rtl/axis_complex_weighter.sv | 184 ++++++++++++++++++
 tb/tb_axis_complex_weighter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_complex_weighter_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_complex_weighter_if
// Brief    : Paired real/imag AXI-Stream bundle with master/slave views.
// Revision : 1.0
// ============================================================================
interface axis_complex_weighter_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   real_tdata;
  logic [DATA_WIDTH/8-1:0] real_tkeep;
  logic                    real_tvalid;
  logic                    real_tlast;
  logic                    real_tready;
  logic [DATA_WIDTH-1:0]   imag_tdata;
  logic [DATA_WIDTH/8-1:0] imag_tkeep;
  logic                    imag_tvalid;
  logic                    imag_tlast;
  logic                    imag_tready;

  modport master (
    output real_tdata, real_tkeep, real_tvalid, real_tlast,
    output imag_tdata, imag_tkeep, imag_tvalid, imag_tlast,
    input  real_tready, imag_tready
  );

  modport slave (
    input  real_tdata, real_tkeep, real_tvalid, real_tlast,
    input  imag_tdata, imag_tkeep, imag_tvalid, imag_tlast,
    output real_tready, imag_tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_complex_weighter.sv
`default_nettype none
// ============================================================================
// Module   : axis_complex_weighter
// Brief    : Complex weight multiply with round/saturate, frame-aligned weights.
// Revision : 1.0
// ============================================================================
module axis_complex_weighter #(
  parameter int SDATA_WIDTH   = 128,
  parameter int SSAMPLE_WIDTH = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int WEIGHT_FRAC   = 7,
  parameter int SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  axis_complex_weighter_if.slave         s_axis,
  axis_complex_weighter_if.master        m_axis,
  input  logic                           weight_wr_en,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_re,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_im,
  output logic [15:0]                    sat_count,
  output logic                           tlast_err
);
  localparam int C_PROD_W = SSAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int C_SUM_W  = C_PROD_W + 1;
  localparam int C_RND_W  = C_SUM_W - WEIGHT_FRAC;
  localparam int C_CNT_W  = $clog2(2 * SAMPLES + 1);
  localparam logic signed [C_SUM_W-1:0] C_ROUND = C_SUM_W'(1) << (WEIGHT_FRAC - 1);

  logic re_pend_q, im_pend_q;
  logic adv, accept;

  assign adv    = (!re_pend_q || m_axis.real_tready) && (!im_pend_q || m_axis.imag_tready);
  assign accept = !reset && adv && s_axis.real_tvalid && s_axis.imag_tvalid;
  assign s_axis.real_tready = !reset && adv && s_axis.imag_tvalid;
  assign s_axis.imag_tready = !reset && adv && s_axis.real_tvalid;

  // Weight double buffer and frame tracking
  logic signed [WEIGHT_WIDTH-1:0] wpend_re_q, wpend_im_q, wact_re_q, wact_im_q;
  logic signed [WEIGHT_WIDTH-1:0] w_use_re, w_use_im;
  logic in_frame_q, last_acc_q, tlast_err_q, w_copy;

  assign w_copy   = last_acc_q || (!in_frame_q && !accept);
  // A frame starting right after tlast must already see the new weight.
  assign w_use_re = last_acc_q ? wpend_re_q : wact_re_q;
  assign w_use_im = last_acc_q ? wpend_im_q : wact_im_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wpend_re_q  <= '0;
      wpend_im_q  <= '0;
      wact_re_q   <= '0;
      wact_im_q   <= '0;
      in_frame_q  <= 1'b0;
      last_acc_q  <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      if (weight_wr_en) begin
        wpend_re_q <= weight_re;
        wpend_im_q <= weight_im;
      end
      if (w_copy) begin
        wact_re_q <= wpend_re_q;
        wact_im_q <= wpend_im_q;
      end
      last_acc_q <= accept && s_axis.real_tlast;
      if (accept) in_frame_q <= !s_axis.real_tlast;
      if (accept && (s_axis.real_tlast != s_axis.imag_tlast)) tlast_err_q <= 1'b1;
    end
  end

  // Stage 1: partial products
  logic                       s1_valid_q, s1_last_q;
  logic signed [C_PROD_W-1:0] p_rr_q [SAMPLES];
  logic signed [C_PROD_W-1:0] p_ii_q [SAMPLES];
  logic signed [C_PROD_W-1:0] p_ri_q [SAMPLES];
  logic signed [C_PROD_W-1:0] p_ir_q [SAMPLES];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= accept;
      s1_last_q  <= s_axis.real_tlast;
      for (int i = 0; i < SAMPLES; i++) begin
        p_rr_q[i] <= C_PROD_W'($signed(s_axis.real_tdata[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH])) * C_PROD_W'(w_use_re);
        p_ii_q[i] <= C_PROD_W'($signed(s_axis.imag_tdata[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH])) * C_PROD_W'(w_use_im);
        p_ri_q[i] <= C_PROD_W'($signed(s_axis.real_tdata[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH])) * C_PROD_W'(w_use_im);
        p_ir_q[i] <= C_PROD_W'($signed(s_axis.imag_tdata[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH])) * C_PROD_W'(w_use_re);
      end
    end
  end

  // Stage 2: complex sum, round half up, drop fractional bits
  logic signed [C_RND_W-1:0] w_rnd_re [SAMPLES];
  logic signed [C_RND_W-1:0] w_rnd_im [SAMPLES];
  logic signed [C_RND_W-1:0] rnd_re_q [SAMPLES];
  logic signed [C_RND_W-1:0] rnd_im_q [SAMPLES];
  logic                      s2_valid_q, s2_last_q;

  for (genvar g = 0; g < SAMPLES; g++) begin : g_round
    logic signed [C_SUM_W-1:0] w_pr, w_pi;
    assign w_pr        = C_SUM_W'(p_rr_q[g]) - C_SUM_W'(p_ii_q[g]);
    assign w_pi        = C_SUM_W'(p_ri_q[g]) + C_SUM_W'(p_ir_q[g]);
    assign w_rnd_re[g] = C_RND_W'((w_pr + C_ROUND) >>> WEIGHT_FRAC);
    assign w_rnd_im[g] = C_RND_W'((w_pi + C_ROUND) >>> WEIGHT_FRAC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      for (int i = 0; i < SAMPLES; i++) begin
        rnd_re_q[i] <= w_rnd_re[i];
        rnd_im_q[i] <= w_rnd_im[i];
      end
    end
  end

  // Stage 3: saturation feeding the shared output slot
  logic [SAMPLES-1:0]     w_clip_re, w_clip_im;
  logic [SDATA_WIDTH-1:0] w_sat_re, w_sat_im;
  logic [C_CNT_W-1:0]     w_clip_cnt;
  logic [16:0]            w_sat_sum;
  logic [15:0]            sat_count_d, sat_count_q;

  for (genvar g = 0; g < SAMPLES; g++) begin : g_sat
    assign w_clip_re[g] = rnd_re_q[g][C_RND_W-1:SSAMPLE_WIDTH-1]
                          != {(C_RND_W-SSAMPLE_WIDTH+1){rnd_re_q[g][C_RND_W-1]}};
    assign w_clip_im[g] = rnd_im_q[g][C_RND_W-1:SSAMPLE_WIDTH-1]
                          != {(C_RND_W-SSAMPLE_WIDTH+1){rnd_im_q[g][C_RND_W-1]}};
    assign w_sat_re[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] = w_clip_re[g]
        ? {rnd_re_q[g][C_RND_W-1], {(SSAMPLE_WIDTH-1){~rnd_re_q[g][C_RND_W-1]}}}
        : rnd_re_q[g][SSAMPLE_WIDTH-1:0];
    assign w_sat_im[g*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] = w_clip_im[g]
        ? {rnd_im_q[g][C_RND_W-1], {(SSAMPLE_WIDTH-1){~rnd_im_q[g][C_RND_W-1]}}}
        : rnd_im_q[g][SSAMPLE_WIDTH-1:0];
  end

  assign w_clip_cnt  = C_CNT_W'($countones({w_clip_re, w_clip_im}));
  assign w_sat_sum   = {1'b0, sat_count_q} + 17'(w_clip_cnt);
  assign sat_count_d = w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];

  logic [SDATA_WIDTH-1:0] out_re_q, out_im_q;
  logic                   out_last_q;

  // Each sink retires its own pending bit; refill waits for both.
  always_ff @(posedge clock) begin
    if (reset) begin
      re_pend_q   <= 1'b0;
      im_pend_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      sat_count_q <= '0;
    end else if (adv) begin
      re_pend_q  <= s2_valid_q;
      im_pend_q  <= s2_valid_q;
      out_last_q <= s2_valid_q && s2_last_q;
      out_re_q   <= w_sat_re;
      out_im_q   <= w_sat_im;
      if (s2_valid_q) sat_count_q <= sat_count_d;
    end else begin
      if (m_axis.real_tready) re_pend_q <= 1'b0;
      if (m_axis.imag_tready) im_pend_q <= 1'b0;
    end
  end

  assign m_axis.real_tdata  = out_re_q;
  assign m_axis.imag_tdata  = out_im_q;
  assign m_axis.real_tvalid = re_pend_q;
  assign m_axis.imag_tvalid = im_pend_q;
  assign m_axis.real_tlast  = out_last_q;
  assign m_axis.imag_tlast  = out_last_q;
  assign m_axis.real_tkeep  = {(SDATA_WIDTH/8){re_pend_q}};
  assign m_axis.imag_tkeep  = {(SDATA_WIDTH/8){im_pend_q}};
  assign sat_count          = sat_count_q;
  assign tlast_err          = tlast_err_q;
endmodule
`default_nettype wire

// File: tb/tb_axis_complex_weighter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_complex_weighter
// Brief    : Scoreboard bench for axis_complex_weighter.
// Revision : 1.0
// ============================================================================
module tb_axis_complex_weighter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axis_complex_weighter_if #(.DATA_WIDTH(128)) s_if ();
  axis_complex_weighter_if #(.DATA_WIDTH(128)) m_if ();

  logic              weight_wr_en;
  logic signed [7:0] weight_re, weight_im;
  logic [15:0]       sat_count;
  logic              tlast_err;

  axis_complex_weighter dut (
    .clock        (clock),
    .reset        (reset),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .weight_wr_en (weight_wr_en),
    .weight_re    (weight_re),
    .weight_im    (weight_im),
    .sat_count    (sat_count),
    .tlast_err    (tlast_err)
  );

  typedef struct {
    logic [127:0] data;
    logic         last;
    int           acc;
  } exp_t;

  exp_t q_re[$];
  exp_t q_im[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0, mode = 0;
  int   n_out_re = 0, n_out_im = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [127:0] fill(input int v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(v);
    return r;
  endfunction

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic void model(input logic [127:0] rd, input logic [127:0] id,
                                input int wr, input int wi,
                                output logic [127:0] er, output logic [127:0] ei);
    longint ar, ai;
    for (int i = 0; i < 8; i++) begin
      ar = longint'($signed(rd[i*16 +: 16]));
      ai = longint'($signed(id[i*16 +: 16]));
      er[i*16 +: 16] = sat16((ar * wr - ai * wi + 64) >>> 7);
      ei[i*16 +: 16] = sat16((ar * wi + ai * wr + 64) >>> 7);
    end
  endfunction

  // Sinks
  initial begin
    m_if.real_tready = 1'b1;
    m_if.imag_tready = 1'b1;
    forever begin
      @(negedge clock);
      if (mode == 0) begin
        m_if.real_tready = 1'b1;
        m_if.imag_tready = 1'b1;
      end else begin
        m_if.real_tready = (cyc % 2 == 0);
        m_if.imag_tready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: a handshake seen here completes on the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (m_if.real_tvalid === 1'b1 && m_if.real_tready === 1'b1) begin
        n_out_re++;
        if (q_re.size() == 0) fail_now("re_unexpected_beat");
        else begin
          e = q_re.pop_front();
          chk("re_data", m_if.real_tdata, e.data);
          chk("re_last", 128'(m_if.real_tlast), 128'(e.last));
          chk("re_keep", 128'(m_if.real_tkeep), 128'h_FFFF);
          if (lat_chk) chk("re_latency", 128'(cyc - e.acc), 128'd3);
        end
      end
      if (m_if.imag_tvalid === 1'b1 && m_if.imag_tready === 1'b1) begin
        n_out_im++;
        if (q_im.size() == 0) fail_now("im_unexpected_beat");
        else begin
          e = q_im.pop_front();
          chk("im_data", m_if.imag_tdata, e.data);
          chk("im_last", 128'(m_if.imag_tlast), 128'(e.last));
          chk("im_keep", 128'(m_if.imag_tkeep), 128'h_FFFF);
          if (lat_chk) chk("im_latency", 128'(cyc - e.acc), 128'd3);
        end
      end
    end
  end

  task automatic send(input logic [127:0] rd, input logic [127:0] id,
                      input logic rl, input logic il,
                      input logic [127:0] er, input logic [127:0] ei, input int idelay);
    exp_t e;
    int   t;
    @(negedge clock);
    s_if.real_tdata  = rd;
    s_if.real_tlast  = rl;
    s_if.real_tvalid = 1'b1;
    s_if.imag_tdata  = id;
    s_if.imag_tlast  = il;
    s_if.imag_tvalid = (idelay == 0);
    for (int k = 0; k < idelay; k++) begin
      #1;
      chk("join_real_ready_early", 128'(s_if.real_tready), 128'd0);
      @(negedge clock);
    end
    s_if.imag_tvalid = 1'b1;
    #1;
    t = 0;
    while (!(s_if.real_tready && s_if.imag_tready)) begin
      if (t > 1000) begin
        fail_now("input_handshake_timeout");
        s_if.real_tvalid = 1'b0;
        s_if.imag_tvalid = 1'b0;
        return;
      end
      t++;
      @(negedge clock);
      #1;
    end
    e.data = er; e.last = rl; e.acc = cyc;
    q_re.push_back(e);
    e.data = ei;
    q_im.push_back(e);
    @(posedge clock);
    #1;
    s_if.real_tvalid = 1'b0;
    s_if.imag_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_re.size() != 0 || q_im.size() != 0) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) fail_now("drain_timeout");
    repeat (2) @(negedge clock);
  endtask

  task automatic set_weight(input int wr, input int wi);
    @(negedge clock);
    weight_wr_en = 1'b1;
    weight_re    = 8'(wr);
    weight_im    = 8'(wi);
    @(negedge clock);
    weight_wr_en = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [127:0] rd, id, er, ei;
    int v;
    reset = 1'b1;
    weight_wr_en = 1'b0;
    weight_re = '0;
    weight_im = '0;
    s_if.real_tkeep  = '1;
    s_if.imag_tkeep  = '1;
    s_if.real_tdata  = fill(1000);
    s_if.imag_tdata  = fill(-1000);
    s_if.real_tlast  = 1'b1;
    s_if.imag_tlast  = 1'b1;
    s_if.real_tvalid = 1'b1;
    s_if.imag_tvalid = 1'b1;

    // Reset held with valid inputs: everything stays quiet
    repeat (4) begin
      @(negedge clock);
      #1;
      chk("reset_ctrl", 128'({m_if.real_tvalid, m_if.imag_tvalid, m_if.real_tlast, m_if.imag_tlast,
                              m_if.real_tkeep, m_if.imag_tkeep, s_if.real_tready, s_if.imag_tready,
                              tlast_err, sat_count}), 128'd0);
      chk("reset_re_data", m_if.real_tdata, 128'd0);
      chk("reset_im_data", m_if.imag_tdata, 128'd0);
    end
    @(negedge clock);
    s_if.real_tvalid = 1'b0;
    s_if.imag_tvalid = 1'b0;
    reset = 1'b0;

    // Gain 0.5, back-to-back, fixed latency
    set_weight(64, 0);
    lat_chk = 1'b1;
    for (int b = 0; b < 100; b++)
      send(fill(1000), fill(-1000), b == 99, b == 99, fill(500), fill(-500), 0);
    drain();
    lat_chk = 1'b0;
    chk("gain_re_count", 128'(n_out_re), 128'd100);
    chk("gain_im_count", 128'(n_out_im), 128'd100);
    chk("gain_sat_count", 128'(sat_count), 128'd0);

    // Saturation: real clips, imag rounds to -1
    set_weight(127, 127);
    for (int b = 0; b < 3; b++)
      send(fill(32767), fill(-32768), b == 2, b == 2, fill(32767), fill(-1), 0);
    drain();
    chk("sat_count_24", 128'(sat_count), 128'd24);
    for (int b = 0; b < 8188; b++)
      send(fill(32767), fill(-32768), b == 8187, b == 8187, fill(32767), fill(-1), 0);
    drain();
    chk("sat_count_65528", 128'(sat_count), 128'd65528);
    send(fill(32767), fill(-32768), 1'b1, 1'b1, fill(32767), fill(-1), 0);
    drain();
    chk("sat_count_max", 128'(sat_count), 128'h_FFFF);
    send(fill(32767), fill(-32768), 1'b1, 1'b1, fill(32767), fill(-1), 0);
    drain();
    chk("sat_count_hold", 128'(sat_count), 128'h_FFFF);

    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("sat_count_reset", 128'(sat_count), 128'd0);

    // Skewed backpressure with a counting pattern
    set_weight(100, -50);
    n_out_re = 0;
    n_out_im = 0;
    mode = 1;
    for (int b = 0; b < 200; b++) begin
      for (int i = 0; i < 8; i++) begin
        v = b * 8 + i - 800;
        rd[i*16 +: 16] = 16'(v);
        id[i*16 +: 16] = 16'(3 * v + 7);
      end
      model(rd, id, 100, -50, er, ei);
      send(rd, id, b == 199, b == 199, er, ei, 0);
    end
    drain();
    mode = 0;
    chk("skew_re_count", 128'(n_out_re), 128'd200);
    chk("skew_im_count", 128'(n_out_im), 128'd200);

    // Join: imag arrives five cycles after real
    model(fill(2000), fill(300), 100, -50, er, ei);
    send(fill(2000), fill(300), 1'b1, 1'b1, er, ei, 5);
    drain();
    chk("join_re_count", 128'(n_out_re), 128'd201);
    chk("join_im_count", 128'(n_out_im), 128'd201);

    // Weight change mid-frame lands on the next frame
    set_weight(64, 0);
    for (int b = 0; b < 8; b++) begin
      if (b == 3) set_weight(32, 0);
      send(fill(1000), fill(-1000), b == 7, b == 7, fill(500), fill(-500), 0);
    end
    drain();
    chk("tlast_err_clear", 128'(tlast_err), 128'd0);
    for (int b = 0; b < 8; b++)
      send(fill(1000), fill(-1000), b == 7, 1'b0, fill(250), fill(-250), 0);
    drain();
    chk("tlast_err_set", 128'(tlast_err), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
